// File: rtl/rf_pkg.sv
// Shared defaults and scalar types for the multi-port register file.
// AW is derived here, and again per instance, so that it always tracks DEPTH.
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NR_RD = 2;
    localparam int RF_NR_WR = 2;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and issue bundle of the register file; the core drives through
// master, the register file sits behind slave.
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int DEPTH = RF_DEPTH,
    parameter int NR_RD = RF_NR_RD,
    parameter int NR_WR = RF_NR_WR,
    parameter int AW    = $clog2(DEPTH)
);

    logic [NR_RD*AW-1:0]   i_rs_addr;
    logic [NR_RD*XLEN-1:0] o_rs_data;
    logic [NR_RD-1:0]      o_rs_busy;
    logic [NR_WR-1:0]      i_wr_en;
    logic [NR_WR*AW-1:0]   i_wr_addr;
    logic [NR_WR*XLEN-1:0] i_wr_data;
    logic                  i_issue_en;
    logic [AW-1:0]         i_issue_addr;
    logic [DEPTH-1:0]      o_busy_vec;

    modport master (
        output i_rs_addr, i_wr_en, i_wr_addr, i_wr_data, i_issue_en, i_issue_addr,
        input  o_rs_data, o_rs_busy, o_busy_vec
    );

    modport slave (
        input  i_rs_addr, i_wr_en, i_wr_addr, i_wr_data, i_issue_en, i_issue_addr,
        output o_rs_data, o_rs_busy, o_busy_vec
    );

endinterface

// File: rtl/rf_wr_select.sv
// Matches one register address against every write port.  When ports collide,
// the highest-index port wins.
module rf_wr_select #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NR_WR = 2
) (
    input  logic [AW-1:0]         addr,
    input  logic [NR_WR-1:0]      wr_en,
    input  logic [NR_WR*AW-1:0]   wr_addr,
    input  logic [NR_WR*XLEN-1:0] wr_data,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    // Ascending scan: a later match overwrites an earlier one, which gives
    // the higher port precedence.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NR_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wr_data[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with an optional write-to-read bypass and a
// per-register busy scoreboard that lets decode stall on RAW hazards.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NR_RD    = RF_NR_RD,
    parameter int NR_WR    = RF_NR_WR,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    regfile_mp_if.slave   bus
);

    logic [XLEN-1:0]  regs_reg [DEPTH];
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] reg_we;
    logic [XLEN-1:0]  wr_val [DEPTH];

    // Per-register write decode.  Register 0 never takes a write when it is
    // hardwired.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [AW-1:0] REG_ADDR = AW'(gi);

            rf_wr_select #(
                .XLEN  (XLEN),
                .AW    (AW),
                .NR_WR (NR_WR)
            ) u_sel (
                .addr    (REG_ADDR),
                .wr_en   (bus.i_wr_en),
                .wr_addr (bus.i_wr_addr),
                .wr_data (bus.i_wr_data),
                .hit     (wr_hit[gi]),
                .data    (wr_val[gi])
            );

            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign reg_we[gi] = 1'b0;
            end else begin : g_norm
                assign reg_we[gi] = wr_hit[gi];
            end
        end
    endgenerate

    // Apply the write clear before the issue set, so that a new producer
    // issued in the same cycle keeps its register busy.
    always_comb begin
        busy_next = busy_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit[i]) begin
                busy_next[i] = 1'b0;
            end
            if (bus.i_issue_en && (bus.i_issue_addr == AW'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reg_we[i]) begin
                    regs_reg[i] <= wr_val[i];
                end
            end
            busy_reg <= busy_next;
        end
    end

    // The outputs are gated by reset so that a write the core drives while
    // reset is held does not reach the read ports through the bypass.
    generate
        for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
            logic [AW-1:0]   rd_addr;
            logic            rd_hit;
            logic [XLEN-1:0] rd_wdata;
            logic            rd_zero;

            assign rd_addr = bus.i_rs_addr[gi*AW +: AW];
            assign rd_zero = (ZERO_REG != 0) && (rd_addr == '0);

            if (BYPASS != 0) begin : g_byp
                rf_wr_select #(
                    .XLEN  (XLEN),
                    .AW    (AW),
                    .NR_WR (NR_WR)
                ) u_sel (
                    .addr    (rd_addr),
                    .wr_en   (bus.i_wr_en),
                    .wr_addr (bus.i_wr_addr),
                    .wr_data (bus.i_wr_data),
                    .hit     (rd_hit),
                    .data    (rd_wdata)
                );
            end else begin : g_nobyp
                assign rd_hit   = 1'b0;
                assign rd_wdata = '0;
            end

            assign bus.o_rs_data[gi*XLEN +: XLEN] =
                (!i_reset || rd_zero) ? '0 :
                rd_hit                ? rd_wdata :
                                        regs_reg[rd_addr];

            assign bus.o_rs_busy[gi] = i_reset && busy_reg[rd_addr] && !rd_hit;
        end
    endgenerate

    assign bus.o_busy_vec = i_reset ? busy_reg : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp.  A bypassing copy and a non-bypassing copy
// receive the same stimulus, and their outputs are checked against a scoreboard.
module tb_regfile_mp;
    import rf_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NR_RD = 2;
    localparam int NR_WR = 2;
    localparam int AW    = 5;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_VEC  = 2;

    localparam int BYP = 0;
    localparam int NOB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NR_RD(NR_RD), .NR_WR(NR_WR)) bus_b ();
    regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NR_RD(NR_RD), .NR_WR(NR_WR)) bus_n ();

    regfile_mp #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NR_RD(NR_RD), .NR_WR(NR_WR),
        .BYPASS(1), .ZERO_REG(1)
    ) u_byp (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus_b.slave)
    );

    regfile_mp #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NR_RD(NR_RD), .NR_WR(NR_WR),
        .BYPASS(0), .ZERO_REG(1)
    ) u_nob (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus_n.slave)
    );

    typedef struct {
        string       tag;
        int          which;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic idle();
        bus_b.i_wr_en    = '0;
        bus_n.i_wr_en    = '0;
        bus_b.i_issue_en = 1'b0;
        bus_n.i_issue_en = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [31:0] d);
        bus_b.i_wr_en[j]               = 1'b1;
        bus_n.i_wr_en[j]               = 1'b1;
        bus_b.i_wr_addr[j*AW +: AW]     = AW'(a);
        bus_n.i_wr_addr[j*AW +: AW]     = AW'(a);
        bus_b.i_wr_data[j*XLEN +: XLEN] = d;
        bus_n.i_wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int k, input int a);
        bus_b.i_rs_addr[k*AW +: AW] = AW'(a);
        bus_n.i_rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int a);
        bus_b.i_issue_en   = 1'b1;
        bus_n.i_issue_en   = 1'b1;
        bus_b.i_issue_addr = AW'(a);
        bus_n.i_issue_addr = AW'(a);
    endtask

    task automatic expect_one(input string tag, input int which, input int kind,
                              input int port, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.which = which;
        e.kind  = kind;
        e.port  = port;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic expect_both(input string tag, input int kind, input int port,
                               input logic [31:0] v);
        expect_one(tag, BYP, kind, port, v);
        expect_one(tag, NOB, kind, port, v);
    endtask

    function automatic logic [31:0] observe(input int which, input int kind, input int port);
        logic [31:0] r;
        r = '0;
        case (kind)
            K_DATA:  r = (which == NOB) ? bus_n.o_rs_data[port*XLEN +: XLEN]
                                        : bus_b.o_rs_data[port*XLEN +: XLEN];
            K_BUSY:  r = {31'b0, (which == NOB) ? bus_n.o_rs_busy[port] : bus_b.o_rs_busy[port]};
            default: r = (which == NOB) ? bus_n.o_busy_vec : bus_b.o_busy_vec;
        endcase
        return r;
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.which, e.kind, e.port);
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s dut=%s port=%0d observed=%h expected=%h",
                       e.tag, (e.which == NOB) ? "nobyp" : "byp", e.port, obs, e.val);
            end
        end
    endtask

    // Inputs are set before the call, combinational outputs are checked mid-cycle,
    // and the next step starts just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_b.i_rs_addr = '0; bus_n.i_rs_addr = '0;
        bus_b.i_wr_addr = '0; bus_n.i_wr_addr = '0;
        bus_b.i_wr_data = '0; bus_n.i_wr_data = '0;
        bus_b.i_issue_addr = '0; bus_n.i_issue_addr = '0;
        idle();

        // Reset held; the write to x5 must not appear on the read port, not even via the bypass.
        set_rd(0, 5);
        set_wr(0, 5, 32'hDEADBEEF);
        issue(6);
        expect_both("rst_hold_data", K_DATA, 0, 32'h0);
        expect_both("rst_hold_busy", K_BUSY, 0, 32'h0);
        expect_both("rst_hold_vec",  K_VEC,  0, 32'h0);
        cycle();

        rst_n = 1'b1;
        idle();
        expect_both("rst_rel_x5", K_DATA, 0, 32'h0);
        expect_both("rst_rel_vec", K_VEC, 0, 32'h0);
        cycle();

        // Write followed by a read of x3.
        set_wr(0, 3, 32'h12345678);
        set_rd(0, 3);
        expect_one("wr_x3_same_nob", NOB, K_DATA, 0, 32'h0);
        expect_one("wr_x3_same_byp", BYP, K_DATA, 0, 32'h12345678);
        cycle();
        idle();
        expect_both("wr_x3_next", K_DATA, 0, 32'h12345678);
        cycle();

        // Bypass on x7 while port 1 writes to the hardwired x0.
        set_wr(0, 7, 32'hA5A5A5A5);
        set_wr(1, 0, 32'hFFFFFFFF);
        set_rd(0, 7);
        set_rd(1, 0);
        expect_one("byp_x7",     BYP, K_DATA, 0, 32'hA5A5A5A5);
        expect_one("nob_x7",     NOB, K_DATA, 0, 32'h0);
        expect_both("byp_x0",    K_DATA, 1, 32'h0);
        cycle();
        idle();
        expect_both("x7_stored", K_DATA, 0, 32'hA5A5A5A5);
        expect_both("x0_stored", K_DATA, 1, 32'h0);
        cycle();

        // Both write ports hit x9; port 1 must win.
        set_wr(0, 9, 32'h1111);
        set_wr(1, 9, 32'h2222);
        set_rd(0, 9);
        expect_one("conf_byp", BYP, K_DATA, 0, 32'h2222);
        expect_one("conf_nob", NOB, K_DATA, 0, 32'h0);
        cycle();
        idle();
        expect_both("conf_stored", K_DATA, 0, 32'h2222);
        cycle();

        // Scoreboard lifecycle for x4.
        issue(4);
        set_rd(0, 4);
        expect_both("sb_c0_busy", K_BUSY, 0, 32'h0);
        expect_both("sb_c0_vec",  K_VEC,  0, 32'h0);
        cycle();
        idle();
        expect_both("sb_c1_busy", K_BUSY, 0, 32'h1);
        expect_both("sb_c1_vec",  K_VEC,  0, 32'h1 << 4);
        cycle();
        expect_both("sb_c2_busy", K_BUSY, 0, 32'h1);
        cycle();
        set_wr(0, 4, 32'h55);
        expect_one("sb_c3_busy_byp", BYP, K_BUSY, 0, 32'h0);
        expect_one("sb_c3_busy_nob", NOB, K_BUSY, 0, 32'h1);
        expect_one("sb_c3_data_byp", BYP, K_DATA, 0, 32'h55);
        expect_one("sb_c3_data_nob", NOB, K_DATA, 0, 32'h0);
        cycle();
        idle();
        expect_both("sb_c4_busy", K_BUSY, 0, 32'h0);
        expect_both("sb_c4_vec",  K_VEC,  0, 32'h0);
        expect_both("sb_c4_data", K_DATA, 0, 32'h55);
        cycle();

        // Issue and write to x8 in the same cycle: the new producer wins.
        issue(8);
        set_wr(1, 8, 32'h77);
        set_rd(1, 8);
        expect_both("iw_same_busy", K_BUSY, 1, 32'h0);
        cycle();
        idle();
        issue(0);
        expect_both("iw_next_vec",  K_VEC,  0, 32'h1 << 8);
        expect_both("iw_next_busy", K_BUSY, 1, 32'h1);
        expect_both("iw_next_data", K_DATA, 1, 32'h77);
        cycle();
        idle();
        issue(8);
        expect_both("issue_x0_vec", K_VEC, 0, 32'h1 << 8);
        cycle();
        idle();
        expect_both("reissue_vec", K_VEC, 0, 32'h1 << 8);
        cycle();

        // Build up state, then assert reset mid-run.
        set_wr(0, 5, 32'hDEADBEEF);
        issue(6);
        cycle();
        idle();
        set_rd(0, 5);
        set_rd(1, 6);
        expect_both("pre_rst_x5",   K_DATA, 0, 32'hDEADBEEF);
        expect_both("pre_rst_busy", K_BUSY, 1, 32'h1);
        expect_both("pre_rst_vec",  K_VEC,  0, (32'h1 << 8) | (32'h1 << 6));
        cycle();
        rst_n = 1'b0;
        set_wr(0, 5, 32'h1);
        issue(10);
        expect_both("mid_rst_data", K_DATA, 0, 32'h0);
        expect_both("mid_rst_busy", K_BUSY, 1, 32'h0);
        expect_both("mid_rst_vec",  K_VEC,  0, 32'h0);
        cycle();
        rst_n = 1'b1;
        idle();
        expect_both("post_rst_x5",   K_DATA, 0, 32'h0);
        expect_both("post_rst_x6",   K_DATA, 1, 32'h0);
        expect_both("post_rst_busy", K_BUSY, 1, 32'h0);
        expect_both("post_rst_vec",  K_VEC,  0, 32'h0);
        cycle();
        set_rd(0, 3);
        expect_both("post_rst_x3", K_DATA, 0, 32'h0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the successor to the single-cycle 2R/1W register file and targets the pipelined core. It adds configurable width, depth and port counts, optional write-to-read bypass, and a per-register busy scoreboard. The scoreboard marks registers with an in-flight producer so that decode can stall on RAW hazards.

Parameters:
XLEN, 32, data width of each register.
DEPTH, 32, number of registers; must be a power of two, at least 2.
NR_RD, 2, number of read ports.
NR_WR, 2, number of write ports.
BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored contents only.
ZERO_REG, 1, 1 = register 0 is hardwired to zero.
AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
i_clk  in  1  clock, rising-edge.
i_reset  in  1  asynchronous, active-low reset.
i_rs_addr  in  NR_RD*AW  read addresses; port k occupies slice [k*AW +: AW].
o_rs_data  out  NR_RD*XLEN  read data per port.
o_rs_busy  out  NR_RD  per-port flag: the addressed register has a pending producer.
i_wr_en  in  NR_WR  write enable per port.
i_wr_addr  in  NR_WR*AW  write addresses.
i_wr_data  in  NR_WR*XLEN  write data.
i_issue_en  in  1  an instruction writing i_issue_addr has issued; set its busy bit.
i_issue_addr  in  AW  destination register of the issued instruction.
o_busy_vec  out  DEPTH  raw scoreboard state, one bit per register.

Behaviour:
- Reset: asynchronous on i_reset low.
  - All registers clear to 0; all busy bits clear to 0.
  - While reset is held: o_rs_data = 0, o_rs_busy = 0, o_busy_vec = 0.
  - Reset asserted mid-operation discards pending writes and issues in that cycle.
- Writes: registers update on the rising edge of i_clk when i_wr_en[j]=1.
  - If several ports target the same address, the highest-index port wins (port 1 beats port 0).
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 regardless of BYPASS.
  - An issue to address 0 never sets busy.
  - o_busy_vec[0] is constantly 0.
- Reads: combinational, zero-cycle latency.
  - BYPASS=1: if any enabled write port targets the read address this cycle, return that write data, using the same highest-index priority rule. Otherwise return the stored value.
  - BYPASS=0: always return the stored value. New data becomes visible the cycle after the write.
- Scoreboard, evaluated at the rising edge:
  - i_issue_en=1 sets busy[i_issue_addr].
  - Any enabled write to address a clears busy[a].
  - Issue and write to the same address in the same cycle: busy stays/becomes 1, because the new producer wins.
  - An issue to an already-busy address leaves busy at 1. There is no counting; the team guarantees in-order writeback per register.
- Busy output: o_rs_busy[k] = busy[addr_k] AND NOT (BYPASS=1 AND an enabled write hits addr_k this cycle).
  - With BYPASS=0, a register being written this cycle still reports busy until the next edge.
- Out-of-range or X addresses cannot occur, because DEPTH is a power of two.
- No internal clock gating; all state sits in one always_ff block with async reset.

Decomposition:
- Shared package rf_pkg:
  - default XLEN, DEPTH and NR_* constants;
  - typedef rf_addr_t (logic [AW-1:0]);
  - typedef rf_data_t (logic [XLEN-1:0]).
- One sub-module: rf_wr_select.
  - Combinational priority match of one address against all write ports.
  - Outputs a hit flag plus the winning data.
  - Instantiated once per read port for bypass and busy masking, and once per register for storage update.

Test Plan:
- Reset: drive i_reset low mid-run after writing x5=0xDEADBEEF and issuing x6, then release. Required: reads of x5 and x6 return 0, o_busy_vec=0.
- Write then read, BYPASS=0: write x3=0x12345678 on port 0. Required: same-cycle read of x3 returns 0; next cycle returns 0x12345678.
- Bypass and zero register, BYPASS=1: same cycle, write x7=0xA5A5A5A5 and write x0=0xFFFFFFFF. Required: read port 0 on x7 returns 0xA5A5A5A5 combinationally; read port 1 on x0 returns 0.
- Write-port conflict: port 0 writes x9=0x1111 and port 1 writes x9=0x2222 in the same cycle. Required: stored value and bypass value are both 0x2222.
- Scoreboard lifecycle: issue x4 at cycle 0. Required: o_busy_vec[4]=1 and o_rs_busy=1 for x4 at cycle 1. Then write x4=0x55 at cycle 3. Required: o_rs_busy=0 in cycle 3 (BYPASS=1) and busy bit clear at cycle 4.
- Simultaneous issue and write: issue x8 while port 1 writes x8=0x77 in the same cycle. Required: next cycle busy[8]=1 and x8 reads 0x77.
